// File: rtl/frame_serializer_pkg.sv
// Shared definitions for the serial word link: default word width, FIFO depth
// and the transmitter state encoding.
package frame_serializer_pkg;

    localparam int BITS_DEFAULT  = 30;
    localparam int DEPTH_DEFAULT = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/frame_serializer_word_fifo.sv
// Small synchronous word FIFO: registered pointers and count,
// combinational read data from the read pointer.
module word_fifo #(
    parameter  int W     = 30,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   cnt_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    // A push while full is refused regardless of a simultaneous pop.
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    assign full  = (cnt_r == (AW+1)'(DEPTH));
    assign empty = (cnt_r == (AW+1)'(0));
    assign level = cnt_r;
    assign dout  = mem_r[rd_ptr_r];

    // Storage, pointers (wrapping modulo DEPTH) and occupancy count.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
                2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/frame_serializer.sv
// Parallel-to-serial transmitter: buffers words in a FIFO and shifts each out
// MSB first, one bit per SHIFT_EN strobe, with no gap between words.
module frame_serializer
    import frame_serializer_pkg::*;
#(
    parameter  int BITS  = BITS_DEFAULT,
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int LW    = $clog2(DEPTH) + 1,
    localparam int CW    = $clog2(BITS)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [BITS-1:0] WORD_IN,
    input  logic            WORD_VALID,
    output logic            WORD_READY,
    input  logic            SHIFT_EN,
    output logic            BIT_OUT,
    output logic            FRAME_SOF,
    output logic            BUSY,
    output logic [LW-1:0]   FIFO_LEVEL
);

    state_e          state_r, state_n_s;
    logic [BITS-1:0] sreg_r, sreg_n_s;
    logic [CW-1:0]   cnt_r, cnt_n_s;
    logic            bit_r, bit_n_s;
    logic            sof_r, sof_n_s;
    logic            alive_r;
    logic            pop_s;
    logic            push_s;
    logic [BITS-1:0] fifo_dout_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [LW-1:0]   fifo_level_s;

    // alive_r keeps WORD_READY low until the first edge after reset release.
    assign WORD_READY = alive_r & ~fifo_full_s;
    assign push_s     = WORD_VALID & WORD_READY;
    assign BIT_OUT    = bit_r;
    assign FRAME_SOF  = sof_r;
    assign BUSY       = (state_r == ST_SHIFT);
    assign FIFO_LEVEL = fifo_level_s;

    word_fifo #(.W(BITS), .DEPTH(DEPTH)) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push_s),
        .din   (WORD_IN),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level_s)
    );

    // Next-state, shift register, bit counter and serial output decode.
    always_comb begin
        state_n_s = state_r;
        sreg_n_s  = sreg_r;
        cnt_n_s   = cnt_r;
        bit_n_s   = bit_r;
        sof_n_s   = sof_r;
        pop_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                bit_n_s = 1'b0;
                sof_n_s = 1'b0;
                if (!fifo_empty_s) begin
                    pop_s     = 1'b1;
                    sreg_n_s  = fifo_dout_s;
                    cnt_n_s   = CW'(BITS - 1);
                    bit_n_s   = fifo_dout_s[BITS-1];
                    sof_n_s   = 1'b1;
                    state_n_s = ST_SHIFT;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!SHIFT_EN) begin
                    state_n_s = ST_SHIFT;
                end else if (cnt_r != CW'(0)) begin
                    sreg_n_s = {sreg_r[BITS-2:0], 1'b0};
                    cnt_n_s  = cnt_r - CW'(1);
                    bit_n_s  = sreg_r[BITS-2];
                    sof_n_s  = 1'b0;
                end else if (!fifo_empty_s) begin
                    // Back-to-back: next word's MSB follows the last bit directly.
                    pop_s    = 1'b1;
                    sreg_n_s = fifo_dout_s;
                    cnt_n_s  = CW'(BITS - 1);
                    bit_n_s  = fifo_dout_s[BITS-1];
                    sof_n_s  = 1'b1;
                end else begin
                    bit_n_s   = 1'b0;
                    sof_n_s   = 1'b0;
                    state_n_s = ST_IDLE;
                end
            end
            default: begin
                bit_n_s   = 1'b0;
                sof_n_s   = 1'b0;
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any frame in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= ST_IDLE;
            sreg_r  <= '0;
            cnt_r   <= '0;
            bit_r   <= 1'b0;
            sof_r   <= 1'b0;
            alive_r <= 1'b0;
        end else begin
            state_r <= state_n_s;
            sreg_r  <= sreg_n_s;
            cnt_r   <= cnt_n_s;
            bit_r   <= bit_n_s;
            sof_r   <= sof_n_s;
            alive_r <= 1'b1;
        end
    end

endmodule
